// File: rtl/fast_nms.sv
// Streaming 3x3 non-maximum suppression over raster-order FAST scores.
// Two line buffers feed a sliding window; one registered result per interior pixel.
module fast_nms #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_score,
  output logic                  out_valid,
  output logic                  out_is_keypoint,
  output logic [X_WIDTH-1:0]    out_x,
  output logic [Y_WIDTH-1:0]    out_y,
  output logic [DATA_WIDTH-1:0] out_score,
  output logic                  frame_done
);

  localparam logic [X_WIDTH-1:0]    COL_LAST = X_WIDTH'(IMG_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0]    ROW_LAST = Y_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [X_WIDTH-1:0]    COL_TWO  = X_WIDTH'(2);
  localparam logic [Y_WIDTH-1:0]    ROW_TWO  = Y_WIDTH'(2);
  localparam logic [X_WIDTH-1:0]    COL_ONE  = X_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0]    ROW_ONE  = Y_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO_D   = {DATA_WIDTH{1'b0}};

  // lb0 holds row r-1, lb1 holds row r-2, both indexed by column
  logic [DATA_WIDTH-1:0] lb0_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_mem [IMG_WIDTH];

  logic [X_WIDTH-1:0] col_r, cur_col_s, col_nxt_s;
  logic [Y_WIDTH-1:0] row_r, cur_row_s, row_nxt_s;

  // Window columns: a = column c-2, b = column c-1 (centre column)
  logic [DATA_WIDTH-1:0] a_top_r, a_mid_r, a_bot_r;
  logic [DATA_WIDTH-1:0] b_top_r, b_mid_r, b_bot_r;
  logic [DATA_WIDTH-1:0] n_top_s, n_mid_s;

  logic fire_s, last_s, kp_s;

  logic                  out_valid_r, out_is_keypoint_r, frame_done_r;
  logic [X_WIDTH-1:0]    out_x_r;
  logic [Y_WIDTH-1:0]    out_y_r;
  logic [DATA_WIDTH-1:0] out_score_r;

  // Effective position, counter advance, window completion and keypoint decision
  always_comb begin
    cur_col_s = in_sof ? {X_WIDTH{1'b0}} : col_r;
    cur_row_s = in_sof ? {Y_WIDTH{1'b0}} : row_r;
    n_top_s   = lb1_mem[cur_col_s];
    n_mid_s   = lb0_mem[cur_col_s];
    col_nxt_s = (cur_col_s == COL_LAST) ? {X_WIDTH{1'b0}} : cur_col_s + COL_ONE;
    row_nxt_s = (cur_col_s != COL_LAST) ? cur_row_s :
                (cur_row_s == ROW_LAST) ? {Y_WIDTH{1'b0}} : cur_row_s + ROW_ONE;
    fire_s    = in_valid && (cur_col_s >= COL_TWO) && (cur_row_s >= ROW_TWO);
    last_s    = (cur_col_s == COL_LAST) && (cur_row_s == ROW_LAST);
    // Strict against earlier-raster neighbours, non-strict against later ones
    kp_s      = (b_mid_r != ZERO_D) &&
                (b_mid_r >  a_top_r) && (b_mid_r >  b_top_r) &&
                (b_mid_r >  n_top_s) && (b_mid_r >  a_mid_r) &&
                (b_mid_r >= n_mid_s) && (b_mid_r >= a_bot_r) &&
                (b_mid_r >= b_bot_r) && (b_mid_r >= in_score);
  end

  // Line buffer storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1_mem[cur_col_s] <= lb0_mem[cur_col_s];
      lb0_mem[cur_col_s] <= in_score;
    end
  end

  // Position counters and window shift on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r   <= {X_WIDTH{1'b0}};
      row_r   <= {Y_WIDTH{1'b0}};
      a_top_r <= ZERO_D;
      a_mid_r <= ZERO_D;
      a_bot_r <= ZERO_D;
      b_top_r <= ZERO_D;
      b_mid_r <= ZERO_D;
      b_bot_r <= ZERO_D;
    end else if (in_valid) begin
      col_r   <= col_nxt_s;
      row_r   <= row_nxt_s;
      a_top_r <= b_top_r;
      a_mid_r <= b_mid_r;
      a_bot_r <= b_bot_r;
      b_top_r <= n_top_s;
      b_mid_r <= n_mid_s;
      b_bot_r <= in_score;
    end
  end

  // Registered result; coordinates and score hold between results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r       <= 1'b0;
      out_is_keypoint_r <= 1'b0;
      frame_done_r      <= 1'b0;
      out_x_r           <= {X_WIDTH{1'b0}};
      out_y_r           <= {Y_WIDTH{1'b0}};
      out_score_r       <= ZERO_D;
    end else begin
      out_valid_r       <= fire_s;
      out_is_keypoint_r <= fire_s && kp_s;
      frame_done_r      <= fire_s && last_s;
      if (fire_s) begin
        out_x_r     <= cur_col_s - COL_ONE;
        out_y_r     <= cur_row_s - ROW_ONE;
        out_score_r <= b_mid_r;
      end
    end
  end

  assign out_valid       = out_valid_r;
  assign out_is_keypoint = out_is_keypoint_r;
  assign frame_done      = frame_done_r;
  assign out_x           = out_x_r;
  assign out_y           = out_y_r;
  assign out_score       = out_score_r;

endmodule

// File: tb/tb_fast_nms.sv
// Directed bench for fast_nms on a 5x5 image with hand-computed keypoint masks.
module tb_fast_nms;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int XW = 3;
  localparam int YW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_score;
  logic          out_valid;
  logic          out_is_keypoint;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [DW-1:0] out_score;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  logic [XW-1:0] last_x;
  logic [YW-1:0] last_y;
  logic [DW-1:0] last_s;

  logic [DW-1:0] img [25];

  fast_nms #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .X_WIDTH(XW), .Y_WIDTH(YW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_score(in_score),
    .out_valid(out_valid), .out_is_keypoint(out_is_keypoint), .out_x(out_x), .out_y(out_y),
    .out_score(out_score), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sends n pixels of img from (0,0); kp is the expected keypoint mask by centre index
  task automatic send_frame(input logic [24:0] kp, input int gap, input int n, input bit sof);
    for (int i = 0; i < n; i++) begin
      int x, y;
      x = i % W;
      y = i / W;
      in_valid = 1'b1;
      in_sof   = sof && (i == 0);
      in_score = img[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (x >= 2 && y >= 2) begin
        last_x = XW'(x - 1);
        last_y = YW'(y - 1);
        last_s = img[(y - 1) * W + (x - 1)];
        chk($sformatf("valid(%0d,%0d)", x, y), {31'd0, out_valid}, 32'd1);
        chk($sformatf("x(%0d,%0d)", x, y), {29'd0, out_x}, {29'd0, last_x});
        chk($sformatf("y(%0d,%0d)", x, y), {29'd0, out_y}, {29'd0, last_y});
        chk($sformatf("score(%0d,%0d)", x, y), {24'd0, out_score}, {24'd0, last_s});
        chk($sformatf("kp(%0d,%0d)", x, y), {31'd0, out_is_keypoint},
            {31'd0, kp[(y - 1) * W + (x - 1)]});
        chk($sformatf("fdone(%0d,%0d)", x, y), {31'd0, frame_done},
            (x == W - 1 && y == H - 1) ? 32'd1 : 32'd0);
      end else begin
        chk($sformatf("novalid(%0d,%0d)", x, y), {31'd0, out_valid}, 32'd0);
        chk($sformatf("nokp(%0d,%0d)", x, y), {31'd0, out_is_keypoint}, 32'd0);
        chk($sformatf("nofdone(%0d,%0d)", x, y), {31'd0, frame_done}, 32'd0);
      end
      for (int g = 0; g < gap; g++) begin
        in_sof   = 1'b1;
        in_score = 8'd77;
        @(posedge clk);
        #1;
        in_sof = 1'b0;
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_fdone", {31'd0, frame_done}, 32'd0);
        chk("idle_kp", {31'd0, out_is_keypoint}, 32'd0);
        chk("idle_xhold", {29'd0, out_x}, {29'd0, last_x});
        chk("idle_shold", {24'd0, out_score}, {24'd0, last_s});
      end
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 25; i++) img[i] = 8'd0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_score = 8'd0;
    last_x   = '0;
    last_y   = '0;
    last_s   = '0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_kp", {31'd0, out_is_keypoint}, 32'd0);
    chk("rst_x", {29'd0, out_x}, 32'd0);
    chk("rst_y", {29'd0, out_y}, 32'd0);
    chk("rst_score", {24'd0, out_score}, 32'd0);
    chk("rst_fdone", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: all-zero frame
    clear_img();
    send_frame(25'd0, 0, 25, 1'b1);

    // 2: single peak at (2,2)
    clear_img();
    img[12] = 8'd20;
    send_frame(25'd1 << 12, 0, 25, 1'b1);

    // 3: tie at (2,2) and (3,2), first in raster order wins
    clear_img();
    img[12] = 8'd25;
    img[13] = 8'd25;
    send_frame(25'd1 << 12, 0, 25, 1'b1);

    // 4: 30 at (2,2) suppressed by 40 at (3,3)
    clear_img();
    img[12] = 8'd30;
    img[18] = 8'd40;
    send_frame(25'd1 << 18, 0, 25, 1'b1);

    // 5: scenario 2 with in_valid every third cycle
    clear_img();
    img[12] = 8'd20;
    send_frame(25'd1 << 12, 2, 25, 1'b1);

    // 6a: 12 random pixels, then abort with in_sof into scenario 2
    for (int i = 0; i < 25; i++) img[i] = 8'($urandom_range(1, 255));
    send_frame(25'd0, 0, 12, 1'b1);
    clear_img();
    img[12] = 8'd20;
    send_frame(25'd1 << 12, 0, 25, 1'b1);

    // 6b: reset mid-frame right after a result, then a frame without in_sof
    send_frame(25'd1 << 12, 0, 13, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_fdone", {31'd0, frame_done}, 32'd0);
    chk("midrst_x", {29'd0, out_x}, 32'd0);
    last_x = '0;
    last_y = '0;
    last_s = '0;
    @(negedge clk);
    rst = 1'b0;
    send_frame(25'd1 << 12, 0, 25, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fast_nms.md
Name: fast_nms

Overview:
- Streaming 3x3 non-maximum suppression stage directly downstream of fast_score.
- Consumes one FAST score per pixel in raster order, buffers two previous rows, and decides per interior pixel whether its score is a local maximum.
- Emits keypoint flag plus (x, y, score) to the descriptor/keypoint FIFO stage.
- No backpressure: accepts one pixel per in_valid and never stalls.

Parameters:
DATA_WIDTH, 8, score width (matches fast_score)
IMG_WIDTH, 640, pixels per row (>= 3)
IMG_HEIGHT, 480, rows per frame (>= 3)
X_WIDTH, 10, column coordinate width (must hold IMG_WIDTH-1)
Y_WIDTH, 9, row coordinate width (must hold IMG_HEIGHT-1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  in_score valid this cycle
in_sof  input  1  start of frame; qualified by in_valid; marks pixel (0,0)
in_score  input  DATA_WIDTH  fast_score output for current pixel (0 = not corner)
out_valid  output  1  one-cycle pulse; window result valid
out_is_keypoint  output  1  centre is a surviving local maximum
out_x  output  X_WIDTH  centre column
out_y  output  Y_WIDTH  centre row
out_score  output  DATA_WIDTH  centre score
frame_done  output  1  one-cycle pulse with result for last frame pixel

Behaviour:
- Reset (async, rst=1): all outputs 0; col/row counters 0; window registers 0. Line-buffer storage is not cleared.
- Pixel accept: in_valid=1. Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance only on accept.
  - col wraps to 0 and row increments.
  - After (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to (0,0).
- in_valid=0 cycles: all state holds; out_valid and frame_done are 0.
- in_sof with in_valid: that pixel is (0,0) regardless of counter state.
  - A mid-frame in_sof aborts the current frame; no result is emitted for the aborted frame's pending window.
  - Stale line-buffer data must never reach an output. This holds because outputs require row >= 2 and col >= 2 of the new frame.
  - in_sof without in_valid is ignored.
- Window: two row buffers of IMG_WIDTH x DATA_WIDTH plus a 3x3 shift window.
  - Accepting the pixel at (c, r) completes the window centred at (c-1, r-1).
- Output condition: accepting (c, r) with c >= 2 and r >= 2 produces, on the next rising edge:
  - out_valid=1
  - out_x=c-1, out_y=r-1
  - out_score = centre score
- Latency is exactly 1 cycle from the accept edge. Border pixels (row/col 0 or last) never produce out_valid.
- Keypoint rule (unsigned compare), out_is_keypoint=1 iff all of the following hold:
  - centre != 0
  - centre > each earlier-raster neighbour (NW, N, NE, W)
  - centre >= each later-raster neighbour (E, SW, S, SE)
  - Effect: on ties the first pixel in raster order wins.
- When out_valid=1 and the keypoint rule fails: out_is_keypoint=0 and out_score still carries the centre score.
- When out_valid=0: out_is_keypoint=0; out_x, out_y and out_score hold their last values.
- frame_done: pulses together with out_valid for the window completed by pixel (IMG_WIDTH-1, IMG_HEIGHT-1), i.e. centre (IMG_WIDTH-2, IMG_HEIGHT-2).
- Back-to-back frames with no idle cycles are supported. Row 0/1 of the next frame emit nothing.
- rst asserted mid-frame: outputs drop to 0 asynchronously. After release the next accepted pixel is (0,0) even without in_sof.

Test Plan (IMG_WIDTH=5, IMG_HEIGHT=5, DATA_WIDTH=8):
1. All-zero frame with in_sof on first pixel, in_valid continuous -> 9 out_valid pulses, centres (1,1)..(3,3) in raster order, all out_is_keypoint=0; frame_done exactly once, coincident with centre (3,3).
2. Score 20 at (2,2), rest 0 -> only (2,2) has out_is_keypoint=1, out_score=20; the other 8 results are 0/not keypoint; each out_valid is 1 cycle after the accept of (x+1, y+1).
3. Score 25 at both (2,2) and (3,2) -> (2,2) keypoint (E tie allowed); (3,2) suppressed (W tie); out_score=25 reported for both.
4. Score 30 at (2,2), 40 at (3,3) -> (3,3) keypoint score 40; (2,2) not a keypoint.
5. Scenario 2 replayed with in_valid high every third cycle -> identical result sequence; out_valid never high on cycles not following an accept.
6. Abort and reset:
   - Send 12 random nonzero pixels, then assert in_sof and send the scenario 2 frame -> 9 results, single keypoint (2,2).
   - Then assert rst mid-frame -> out_valid and frame_done read 0 immediately; after release, a full scenario 2 frame without in_sof reproduces scenario 2.
